// File: rtl/recv_cheat.sv
// recv_cheat: decodes peer cheat requests and holds cheat_activate open for HOLD_CYCLES.
// Define RECV_CHEAT_ACK_EN to add the ACK_WAIT state and the one-shot ack return path.
module recv_cheat #(
    parameter logic       PLAYER        = 1'b0,
    parameter logic [3:0] MSG_CHEAT     = 4'd10,
    parameter logic [3:0] MSG_CHEAT_ACK = 4'd11,
    parameter logic [3:0] STATE_INIT    = 4'd0,
    parameter logic [3:0] STATE_FINISH  = 4'd15,
    parameter int         HOLD_CYCLES   = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interboard_rst,
    input  logic [3:0] cur_game_state,
    input  logic       interboard_en,
    input  logic [3:0] interboard_msg_type,
    input  logic       inter_ready,
    output logic       cheat_activate,
    output logic       ack_ctrl_en,
    output logic [3:0] ack_ctrl_msg_type,
    output logic       ack_src_player
);
    localparam int TW = $clog2(HOLD_CYCLES);
    localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYCLES - 1);
`ifdef RECV_CHEAT_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACTIVE, ACK_WAIT} state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic            w_bad_state;
    logic            w_valid;
    logic            w_ack;
    logic [TW-1:0]   w_dec;
    state_t          w_open;

    assign w_bad_state = (cur_game_state == STATE_INIT) || (cur_game_state == STATE_FINISH);
    assign w_valid     = interboard_en && (interboard_msg_type == MSG_CHEAT) && !w_bad_state;
    // ack is a handshake with inter_ready, so it is qualified in the same cycle
    assign w_ack       = ACK_EN && (r_state == ACK_WAIT) && inter_ready && !w_bad_state && !interboard_rst;
    assign w_dec       = (r_timer == '0) ? '0 : r_timer - 1'b1;
    assign w_open      = ACK_EN ? ACK_WAIT : ACTIVE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else if (interboard_rst || (r_state != IDLE && w_bad_state)) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else if (w_valid) begin
            r_timer <= RELOAD;
            r_state <= (r_state == IDLE) ? w_open : (w_ack ? ACTIVE : r_state);
        end else if (r_state == ACK_WAIT) begin
            r_timer <= w_dec;
            r_state <= w_ack ? ACTIVE : ACK_WAIT;
        end else if (r_state == ACTIVE) begin
            r_timer <= w_dec;
            r_state <= (r_timer == '0) ? IDLE : ACTIVE;
        end
    end

    assign cheat_activate    = (r_state != IDLE);
    assign ack_ctrl_en       = w_ack;
    assign ack_ctrl_msg_type = w_ack ? MSG_CHEAT_ACK : 4'd0;
    assign ack_src_player    = w_ack & PLAYER;
endmodule
